uart_tx_fifo: RTL
=================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG, default 4, meaning FIFO depth = 2^DEPTH_LOG bytes (legal range 1..8).
REQ-002 SHALL have port CLK  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port RST_X  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port IN_DATA  input  8  byte offered by the producer.
REQ-005 SHALL have port IN_WE  input  1  push strobe; IN_DATA is written when IN_WE=1 and IN_FULL=0.
REQ-006 SHALL have port IN_FULL  output  1  FIFO holds 2^DEPTH_LOG bytes.
REQ-007 SHALL have port EMPTY  output  1  FIFO holds 0 bytes and no transfer is in flight.
REQ-008 SHALL have port OVERFLOW  output  1  sticky flag: a push was attempted while IN_FULL=1.
REQ-009 SHALL have port TX_DATA  output  8  byte to the UART transmitter.
REQ-010 SHALL have port TX_WE  output  1  one-cycle write strobe to the UART transmitter.
REQ-011 SHALL have port TX_READY  input  1  transmitter idle and able to accept a byte.
REQ-012 SHALL have port COUNT  output  DEPTH_LOG+1  occupancy, present only under UART_TXFIFO_COUNT_EN.

Function
REQ-013 SHALL store bytes in a circular buffer with DEPTH_LOG-bit read and write pointers that wrap from 2^DEPTH_LOG-1 to 0.
REQ-014 SHALL derive IN_FULL and internal empty from an occupancy counter of width DEPTH_LOG+1, not from pointer equality alone.
REQ-015 SHALL reject a push when IN_FULL=1, even if a pop occurs in the same cycle; data is not written and OVERFLOW sets to 1 on the next edge.
REQ-016 SHALL accept a push and a pop in the same cycle when not full, leaving occupancy unchanged.
REQ-017 SHALL run a drain FSM with states IDLE, ISSUE, HOLD.
REQ-018 In IDLE, when the FIFO is non-empty and TX_READY=1, the FSM SHALL pop the head byte into the registered TX_DATA, set TX_WE=1 on the next edge, and go to ISSUE.
REQ-019 In ISSUE, the FSM SHALL clear TX_WE on the next edge (TX_WE is high for exactly one cycle) and go to HOLD.
REQ-020 In HOLD, the FSM SHALL return to IDLE on the first edge where TX_READY=1, so that a new byte is never issued before the transmitter reports ready again.
REQ-021 TX_DATA SHALL hold its value from issue until the next issue.
REQ-022 Minimum latency from push (FIFO empty, FSM in IDLE, TX_READY=1) to TX_WE=1 SHALL be 2 cycles.
REQ-023 Bytes SHALL leave on TX_DATA in push order, with no loss or duplication.
REQ-024 EMPTY SHALL be 1 only when occupancy=0 and the FSM is in IDLE.

Reset
REQ-025 RST_X=0 SHALL asynchronously force pointers=0, occupancy=0, FSM=IDLE, TX_WE=0, TX_DATA=8'h00, OVERFLOW=0, IN_FULL=0 and EMPTY=1.
REQ-026 Reset asserted mid-transfer SHALL discard all stored bytes; no TX_WE is produced until new data is pushed after reset is released.
REQ-027 OVERFLOW SHALL clear only on reset.

Configuration
REQ-028 With UART_TXFIFO_COUNT_EN defined, COUNT SHALL equal the current occupancy (0..2^DEPTH_LOG), updated on the same edge as push and pop.
REQ-029 Without UART_TXFIFO_COUNT_EN, the COUNT port SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-030 The FSM state encodings and the default DEPTH_LOG SHALL live in a shared uart package/include, alongside the UART definitions.
REQ-031 The storage array with its pointers SHALL be a sub-module named uart_fifo_mem; the FSM and flags SHALL live in uart_tx_fifo.
REQ-032 The block SHALL be drop-in upstream of UartTx: TX_DATA/TX_WE/TX_READY map to its data, we and ready ports.

Verification
REQ-033 Single byte: push 8'h61 with TX_READY=1 held -> TX_WE=1 exactly 2 cycles later with TX_DATA=8'h61, then EMPTY=1.
REQ-034 Ordering: push 8'h61..8'h64 back-to-back while TX_READY toggles as a real UartTx would -> four TX_WE pulses carrying 61,62,63,64 in order.
REQ-035 Full/overflow (DEPTH_LOG=2): hold TX_READY=0 and push 5 bytes -> IN_FULL=1 after the 4th, 5th push rejected, OVERFLOW=1; then release -> only the first 4 bytes are emitted.
REQ-036 Wrap: 3 rounds of filling and draining 2^DEPTH_LOG bytes -> pointers wrap, data intact, COUNT returns to 0 (macro on).
REQ-037 Simultaneous push/pop at occupancy 1 -> occupancy stays 1, byte order preserved.
REQ-038 Reset during HOLD with 3 bytes queued -> TX_WE=0, EMPTY=1, and no further TX_WE after RST_X=1.

Source files
------------

// File: rtl/uart_tx_fifo_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_pkg
//   Shared UART definitions for the transmit path: byte width, byte type,
//   the default transmit-FIFO depth and the drain FSM state encoding.
//   Imported by uart_fifo_mem and uart_tx_fifo.
// ---------------------------------------------------------------------------
package uart_tx_fifo_pkg;

  // UART character width (8N1 framing, data bits only).
  localparam int UART_DATA_W = 8;

  // Default FIFO depth is 2**DEPTH_LOG_DEFAULT bytes.
  localparam int DEPTH_LOG_DEFAULT = 4;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

  // Drain FSM: IDLE waits for data + ready, ISSUE is the single TX_WE cycle,
  // HOLD waits for the transmitter to report ready again.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } drain_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// ---------------------------------------------------------------------------
// uart_fifo_mem
//   Circular byte buffer with DEPTH_LOG-bit read/write pointers that wrap
//   naturally from 2**DEPTH_LOG-1 to 0. Occupancy tracking and the full/empty
//   guards live in the parent; this block trusts wr_en/rd_en.
//
// Ports
//   CLK      in   system clock, rising edge
//   RST_X    in   asynchronous active-low reset (pointers only)
//   wr_en    in   write wr_data at the write pointer and advance it
//   wr_data  in   byte to store
//   rd_en    in   advance the read pointer (head byte consumed)
//   rd_data  out  current head byte (combinational read)
// ---------------------------------------------------------------------------
module uart_fifo_mem
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG = DEPTH_LOG_DEFAULT
) (
  input  logic       CLK,
  input  logic       RST_X,
  input  logic       wr_en,
  input  uart_byte_t wr_data,
  input  logic       rd_en,
  output uart_byte_t rd_data
);

  localparam int DEPTH = 1 << DEPTH_LOG;

  logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
  uart_byte_t           mem_q [DEPTH];

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + DEPTH_LOG'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + DEPTH_LOG'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; zero occupancy makes
  // its contents unobservable, and a reset would prevent RAM inference.
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   Byte FIFO feeding a UartTx transmitter. A producer pushes bytes with
//   IN_WE; a three-state drain FSM pops the head byte into a registered
//   TX_DATA and pulses TX_WE for one cycle whenever the transmitter reports
//   TX_READY, then waits for TX_READY again before issuing the next byte.
//   TX_DATA/TX_WE/TX_READY connect straight to UartTx data/we/ready.
//
// Configuration macro
//   UART_TXFIFO_COUNT_EN  when defined, exposes the COUNT occupancy port.
//
// Ports
//   CLK       in   system clock, rising edge
//   RST_X     in   asynchronous active-low reset
//   IN_DATA   in   byte offered by the producer
//   IN_WE     in   push strobe, accepted only while IN_FULL=0
//   IN_FULL   out  FIFO holds 2**DEPTH_LOG bytes
//   EMPTY     out  FIFO holds 0 bytes and the drain FSM is idle
//   OVERFLOW  out  sticky: a push was attempted while full (reset clears)
//   TX_DATA   out  byte to the transmitter, held between issues
//   TX_WE     out  one-cycle write strobe to the transmitter
//   TX_READY  in   transmitter idle and able to accept a byte
//   COUNT     out  occupancy 0..2**DEPTH_LOG (UART_TXFIFO_COUNT_EN only)
// ---------------------------------------------------------------------------
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG = DEPTH_LOG_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 RST_X,
  input  logic [7:0]           IN_DATA,
  input  logic                 IN_WE,
  output logic                 IN_FULL,
  output logic                 EMPTY,
  output logic                 OVERFLOW,
  output logic [7:0]           TX_DATA,
  output logic                 TX_WE,
  input  logic                 TX_READY
`ifdef UART_TXFIFO_COUNT_EN
  ,
  output logic [DEPTH_LOG:0]   COUNT
`endif
);

  localparam int                DEPTH    = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] OCC_FULL = (DEPTH_LOG+1)'(DEPTH);
  localparam logic [DEPTH_LOG:0] OCC_ONE  = (DEPTH_LOG+1)'(1);

  drain_state_t        state_q,   state_d;
  logic [DEPTH_LOG:0]  occ_q,     occ_d;
  logic                tx_we_q,   tx_we_d;
  uart_byte_t          tx_data_q, tx_data_d;
  logic                ovf_q,     ovf_d;

  logic       full;
  logic       push_ok;
  logic       pop;
  uart_byte_t head_data;

  // Full/empty come from the occupancy counter: with equal pointers alone a
  // full buffer would be indistinguishable from an empty one.
  assign full    = (occ_q == OCC_FULL);
  // A push while full is dropped even if a pop frees a slot on the same edge.
  assign push_ok = IN_WE && !full;
  assign pop     = (state_q == IDLE) && (occ_q != '0) && TX_READY;

  uart_fifo_mem #(
    .DEPTH_LOG (DEPTH_LOG)
  ) u_mem (
    .CLK     (CLK),
    .RST_X   (RST_X),
    .wr_en   (push_ok),
    .wr_data (IN_DATA),
    .rd_en   (pop),
    .rd_data (head_data)
  );

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    // TX_WE defaults low so it can only be high in the cycle after a pop.
    tx_we_d   = 1'b0;
    ovf_d     = ovf_q | (IN_WE & full);

    unique case ({push_ok, pop})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase

    unique case (state_q)
      IDLE: begin
        if (pop) begin
          tx_data_d = head_data;
          tx_we_d   = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: state_d = HOLD;
      // Wait here until the transmitter has consumed the byte and is ready
      // again; IDLE then re-checks TX_READY before the next issue.
      HOLD: begin
        if (TX_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q   <= IDLE;
      occ_q     <= '0;
      tx_we_q   <= 1'b0;
      tx_data_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      occ_q     <= occ_d;
      tx_we_q   <= tx_we_d;
      tx_data_q <= tx_data_d;
      ovf_q     <= ovf_d;
    end
  end

  assign IN_FULL  = full;
  assign EMPTY    = (occ_q == '0) && (state_q == IDLE);
  assign OVERFLOW = ovf_q;
  assign TX_DATA  = tx_data_q;
  assign TX_WE    = tx_we_q;

`ifdef UART_TXFIFO_COUNT_EN
  assign COUNT = occ_q;
`endif

endmodule
